// File: rtl/rs232_pkg.sv
// Shared constants for the RS-232 receive path: byte width, default FIFO depth
// and default RTS flow-control thresholds.
package rs232_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned DEF_DEPTH_LOG2 = 4;
   localparam int unsigned DEF_RTS_HIGH   = 12;
   localparam int unsigned DEF_RTS_LOW    = 4;

   typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/rs232in_fifo_mem.sv
// Receive FIFO storage: one synchronous write port, one asynchronous read port,
// contents are never reset.
module rs232in_fifo_mem
   import rs232_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_DEPTH_LOG2,
   parameter int unsigned DATA_W = BYTE_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rs232in_fifo.sv
// First-word-fall-through receive FIFO with sticky overrun, saturating drop
// counter and optional RTS hysteresis (enabled by defining RS232IN_FIFO_RTS_EN).
module rs232in_fifo
   import rs232_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int unsigned RTS_HIGH   = DEF_RTS_HIGH,
   parameter int unsigned RTS_LOW    = DEF_RTS_LOW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_attention,
   input  logic [BYTE_W-1:0]   rx_data,
   input  logic                rd_strobe,
   output logic [BYTE_W-1:0]   rd_data,
   output logic                rd_valid,
   output logic [DEPTH_LOG2:0] count,
   output logic                overrun,
   input  logic                overrun_clr,
   output logic [7:0]          drop_count,
   output logic                ser_nrts
);

   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count_next;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  drop;

   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds when accompanied by a valid pop.
   always_comb begin
      full       = (count == FULL_CNT);
      rd_valid   = (count != '0);
      pop        = rd_strobe && rd_valid;
      push       = rx_attention && (!full || pop);
      drop       = rx_attention && full && !pop;
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_ONE;
      end else if (pop && !push) begin
         count_next = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overrun    <= 1'b0;
         drop_count <= '0;
      end else begin
         count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
         if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

   rs232in_fifo_mem #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (BYTE_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push && rst_n),
      .wr_addr (wr_ptr),
      .wr_data (rx_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

`ifdef RS232IN_FIFO_RTS_EN
   localparam logic [DEPTH_LOG2:0] RTS_HI_CNT = (DEPTH_LOG2+1)'(RTS_HIGH);
   localparam logic [DEPTH_LOG2:0] RTS_LO_CNT = (DEPTH_LOG2+1)'(RTS_LOW);

   // Hysteresis is evaluated on the post-edge occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ser_nrts <= 1'b0;
      end else if (count_next >= RTS_HI_CNT) begin
         ser_nrts <= 1'b1;
      end else if (count_next <= RTS_LO_CNT) begin
         ser_nrts <= 1'b0;
      end
   end
`else
   logic unused_rts;

   assign ser_nrts   = 1'b0;
   assign unused_rts = (RTS_HIGH > RTS_LOW);
`endif

endmodule

// File: tb/tb_rs232in_fifo.sv
// Self-checking bench for rs232in_fifo: directed scenarios then randomized
// traffic, all compared against a queue-based reference model.
module tb_rs232in_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_attention = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rd_strobe = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [4:0] count;
   logic       overrun;
   logic       overrun_clr = 1'b0;
   logic [7:0] drop_count;
   logic       ser_nrts;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // reference model state
   byte unsigned q[$];
   bit           m_overrun = 0;
   int unsigned  m_drops = 0;
   bit           m_rts = 0;

`ifdef RS232IN_FIFO_RTS_EN
   localparam bit RTS_ON = 1'b1;
`else
   localparam bit RTS_ON = 1'b0;
`endif

   rs232in_fifo #(
      .DEPTH_LOG2 (4),
      .RTS_HIGH   (12),
      .RTS_LOW    (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_attention (rx_attention),
      .rx_data      (rx_data),
      .rd_strobe    (rd_strobe),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr),
      .drop_count   (drop_count),
      .ser_nrts     (ser_nrts)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit att, input byte unsigned d, input bit rds, input bit clr);
      bit full_b;
      bit pop_b;
      full_b = (q.size() == 16);
      pop_b  = rds && (q.size() != 0);
      if (pop_b) void'(q.pop_front());
      if (att && (!full_b || pop_b)) q.push_back(d);
      if (att && full_b && !pop_b) begin
         m_overrun = 1;
         if (m_drops < 255) m_drops++;
      end else if (clr) begin
         m_overrun = 0;
      end
      if (RTS_ON) begin
         if (q.size() >= 12) m_rts = 1;
         else if (q.size() <= 4) m_rts = 0;
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_overrun = 0;
      m_drops = 0;
      m_rts = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/count"}, 32'(count), 32'(q.size()));
      chk({tag, "/rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk({tag, "/rd_data"}, 32'(rd_data), 32'(q[0]));
      chk({tag, "/overrun"}, 32'(overrun), 32'(m_overrun));
      chk({tag, "/drop_count"}, 32'(drop_count), m_drops);
      chk({tag, "/ser_nrts"}, 32'(ser_nrts), 32'(m_rts));
   endtask

   // Inputs change 1 ns after the rising edge; outputs are checked there too.
   task automatic cycle(input bit att, input byte unsigned d, input bit rds, input bit clr);
      rx_attention = att;
      rx_data      = d;
      rd_strobe    = rds;
      overrun_clr  = clr;
      @(posedge clk);
      model_step(att, d, rds, clr);
      #1;
      rx_attention = 1'b0;
      rd_strobe    = 1'b0;
      overrun_clr  = 1'b0;
   endtask

   task automatic do_reset(input bit att);
      rst_n        = 1'b0;
      rx_attention = att;
      rx_data      = 8'hEE;
      @(posedge clk);
      model_reset();
      #1;
      rst_n        = 1'b1;
      rx_attention = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset(1'b0);
      check_all("reset");
      chk("reset_count", 32'(count), 0);
      chk("reset_valid", 32'(rd_valid), 0);
      chk("reset_nrts", 32'(ser_nrts), 0);

      // three bytes in, three out in order
      cycle(1, 8'h41, 0, 0);
      chk("lat1_valid", 32'(rd_valid), 1);
      chk("lat1_data", 32'(rd_data), 32'h41);
      cycle(1, 8'h42, 0, 0);
      cycle(1, 8'h43, 0, 0);
      chk("p3_valid", 32'(rd_valid), 1);
      chk("p3_data", 32'(rd_data), 32'h41);
      chk("p3_count", 32'(count), 3);
      for (int i = 0; i < 3; i++) begin
         chk("p3_order", 32'(rd_data), 32'h41 + 32'(i));
         cycle(0, 8'h00, 1, 0);
      end
      chk("p3_empty_count", 32'(count), 0);
      chk("p3_empty_valid", 32'(rd_valid), 0);
      cycle(0, 8'h00, 1, 0);
      check_all("pop_empty");

      // overflow by one
      for (int i = 0; i <= 16; i++) cycle(1, 8'(i), 0, 0);
      chk("ovf_count", 32'(count), 16);
      chk("ovf_overrun", 32'(overrun), 1);
      chk("ovf_drops", 32'(drop_count), 1);
      for (int i = 0; i < 16; i++) begin
         chk("ovf_order", 32'(rd_data), 32'(i));
         cycle(0, 8'h00, 1, 0);
      end
      check_all("ovf_drained");
      chk("ovf_sticky", 32'(overrun), 1);
      cycle(0, 8'h00, 0, 1);
      chk("ovf_clr", 32'(overrun), 0);

      // full + simultaneous push/pop
      for (int i = 0; i < 16; i++) cycle(1, 8'h60 + 8'(i), 0, 0);
      cycle(1, 8'h55, 1, 0);
      chk("fullpp_count", 32'(count), 16);
      chk("fullpp_overrun", 32'(overrun), 0);
      chk("fullpp_drops", 32'(drop_count), 1);
      for (int i = 0; i < 16; i++) begin
         chk("fullpp_order", 32'(rd_data), (i == 15) ? 32'h55 : 32'h61 + 32'(i));
         cycle(0, 8'h00, 1, 0);
      end
      check_all("fullpp_drained");

      // empty + simultaneous push/pop: push wins, pop ignored
      cycle(1, 8'h77, 1, 0);
      chk("emptypp_count", 32'(count), 1);
      chk("emptypp_data", 32'(rd_data), 32'h77);
      cycle(0, 8'h00, 1, 0);

      // drop counter saturation and clear priority
      do_reset(1'b0);
      for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
      for (int i = 0; i < 300; i++) cycle(1, 8'hAA, 0, 0);
      chk("sat_drops", 32'(drop_count), 255);
      chk("sat_overrun", 32'(overrun), 1);
      cycle(0, 8'h00, 0, 1);
      chk("sat_clr_overrun", 32'(overrun), 0);
      chk("sat_clr_drops", 32'(drop_count), 255);
      cycle(1, 8'hBB, 0, 1);
      chk("clr_vs_drop", 32'(overrun), 1);
      check_all("sat_end");

      // RTS hysteresis
      do_reset(1'b0);
      for (int i = 0; i < 11; i++) cycle(1, 8'(i), 0, 0);
      chk("rts_at11", 32'(ser_nrts), 0);
      cycle(1, 8'd11, 0, 0);
      chk("rts_at12", 32'(ser_nrts), 32'(RTS_ON));
      for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1, 0);
      chk("rts_at5_count", 32'(count), 5);
      chk("rts_at5", 32'(ser_nrts), 32'(RTS_ON));
      cycle(0, 8'h00, 1, 0);
      chk("rts_at4", 32'(ser_nrts), 0);
      check_all("rts_end");

      // reset mid-operation with a coincident receive strobe
      for (int i = 0; i < 10; i++) cycle(1, 8'h30 + 8'(i), 0, 0);
      cycle(1, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++) cycle(1, 8'h00, 0, 0);
      do_reset(1'b1);
      chk("midrst_count", 32'(count), 0);
      chk("midrst_valid", 32'(rd_valid), 0);
      chk("midrst_overrun", 32'(overrun), 0);
      chk("midrst_drops", 32'(drop_count), 0);
      cycle(0, 8'h00, 0, 0);
      check_all("midrst_after");

      // randomized traffic: fill-biased phase, then drain-biased phase
      for (int i = 0; i < 600; i++) begin
         bit att;
         bit rds;
         bit clr;
         if (i < 300) begin
            att = ($urandom_range(0, 3) != 0);
            rds = ($urandom_range(0, 3) == 0);
         end else begin
            att = ($urandom_range(0, 3) == 0);
            rds = ($urandom_range(0, 3) != 0);
         end
         clr = ($urandom_range(0, 15) == 0);
         cycle(att, 8'($urandom), rds, clr);
         check_all("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
